mem_sp_burst_reader: RTL and testbench
======================================

MEM_SP_BURST_READER -- requirements
Module: mem_sp_burst_reader

Interface
REQ-001 The module SHALL have parameter DATA_BIT, default 32, memory word width in bits.
REQ-002 The module SHALL have parameter DEPTH, default 128, memory depth in words.
REQ-003 The module SHALL have parameter ADDR_BIT, default $clog2(DEPTH), memory address width.
REQ-004 The module SHALL have parameter RD_LAT, default 2, cycles from the mem_ren=1 edge to valid mem_rdata sample.
REQ-005 The module SHALL have parameter FIFO_DEPTH, default 4, output buffer entries, always >= RD_LAT+1.
REQ-006 clk  input  1  single clock; all logic on posedge clk.
REQ-007 rst_n  input  1  reset; asynchronous, active-low.
REQ-008 req_valid  input  1  burst request valid.
REQ-009 req_ready  output  1  request accepted when req_valid&req_ready.
REQ-010 req_addr  input  ADDR_BIT  first word address.
REQ-011 req_len  input  ADDR_BIT+1  burst length in words, 0..DEPTH.
REQ-012 mem_addr  output  ADDR_BIT  address to single-port memory.
REQ-013 mem_ren  output  1  active-high read enable to memory.
REQ-014 mem_wen  output  1  active-high write enable, constant 0.
REQ-015 mem_wdata  output  DATA_BIT  constant 0.
REQ-016 mem_bwe  output  DATA_BIT  constant 0.
REQ-017 mem_rdata  input  DATA_BIT  read data from memory.
REQ-018 out_valid  output  1  out_data valid.
REQ-019 out_ready  input  1  downstream accepts when out_valid&out_ready.
REQ-020 out_data  output  DATA_BIT  read word, in address order.
REQ-021 out_last  output  1  asserted with final word of burst.
REQ-022 busy  output  1  high from request acceptance until done pulse.
REQ-023 done  output  1  one-cycle pulse at burst completion.

Function
REQ-024 The state machine SHALL have states IDLE, ISSUE, DRAIN; req_ready SHALL equal (state==IDLE).
REQ-025 In IDLE, on req handshake with req_len>0, the module SHALL latch addr/len, assert busy, and move to ISSUE next cycle.
REQ-026 On req handshake with req_len==0, the module SHALL issue no reads, stay in IDLE, and pulse done the next cycle with busy low.
REQ-027 In ISSUE, a read SHALL be issued (mem_ren=1) in any cycle where inflight_count + fifo_count < FIFO_DEPTH; otherwise mem_ren=0.
REQ-028 Issued addresses SHALL be req_addr, req_addr+1, ... modulo DEPTH (wrap from DEPTH-1 to 0).
REQ-029 After the final read is issued, the state SHALL move to DRAIN; mem_ren SHALL be 0 in IDLE and DRAIN.
REQ-030 mem_addr SHALL hold its last value when mem_ren=0.
REQ-031 mem_rdata SHALL be written into the FIFO exactly RD_LAT cycles after each mem_ren=1 cycle, tracked by a RD_LAT-deep valid shift register.
REQ-032 The FIFO SHALL never overflow; simultaneous push and pop at full or empty SHALL be correct (first-word fall-through, out_valid = fifo not empty).
REQ-033 Minimum latency from the mem_ren cycle to out_valid SHALL be RD_LAT+1 cycles... no: out_valid SHALL rise in the same cycle the word is written into an empty FIFO plus one (registered FIFO), i.e. RD_LAT+1 cycles after issue.
REQ-034 With out_ready held high, sustained throughput SHALL be one word per cycle.
REQ-035 out_data/out_last SHALL be stable while out_valid=1 and out_ready=0.
REQ-036 out_last SHALL be 1 only on the req_len-th output word.
REQ-037 In DRAIN, upon handshake of the out_last word, the module SHALL pulse done, drop busy, and return to IDLE in the same cycle.
REQ-038 A new request SHALL NOT be accepted until the cycle after done.

Reset
REQ-039 While rst_n=0: state=IDLE, req_ready=1, mem_ren=0, mem_addr=0, out_valid=0, out_last=0, out_data=0, busy=0, done=0, FIFO and in-flight tracker empty.
REQ-040 Reset asserted mid-burst SHALL abort immediately; in-flight returning data SHALL be discarded; no done pulse.

Verification
REQ-041 Burst addr=5, len=4, out_ready=1 -> mem_ren 4 consecutive cycles addr 5..8, out words mem[5..8], out_last on 4th, done once.
REQ-042 Wrap: addr=126, len=4, DEPTH=128 -> addresses 126,127,0,1 in order.
REQ-043 Backpressure: len=10, out_ready=0 -> exactly FIFO_DEPTH reads issued then mem_ren=0 held; release out_ready -> remaining 6 words in order, no loss/duplication.
REQ-044 len=0 -> no mem_ren, done pulse next cycle, req_ready stays 1.
REQ-045 rst_n low 3 cycles into len=8 burst -> all outputs at reset values; new len=2 burst afterwards returns only its 2 words.
REQ-046 Random out_ready toggling, len=DEPTH -> all DEPTH words match memory model, one out_last, one done.

Source files
------------

// File: rtl/mem_sp_burst_reader.sv
// Burst reader: streams req_len words from a single-port memory, in address order, into a FWFT output buffer.
// Latency: first out_valid RD_LAT+1 cycles after the first mem_ren; one word per cycle thereafter.
// Backpressure: reads are throttled so in-flight plus buffered words never exceed FIFO_DEPTH.
module mem_sp_burst_reader #(
    parameter int DATA_BIT   = 32,
    parameter int DEPTH      = 128,
    parameter int ADDR_BIT   = $clog2(DEPTH),
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [ADDR_BIT-1:0] req_addr,
    input  logic [ADDR_BIT:0]   req_len,
    output logic [ADDR_BIT-1:0] mem_addr,
    output logic                mem_ren,
    output logic                mem_wen,
    output logic [DATA_BIT-1:0] mem_wdata,
    output logic [DATA_BIT-1:0] mem_bwe,
    input  logic [DATA_BIT-1:0] mem_rdata,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_BIT-1:0] out_data,
    output logic                out_last,
    output logic                busy,
    output logic                done
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + RD_LAT + 2);
    localparam logic [ADDR_BIT:0] LEN_ONE = 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t              state;
    logic [ADDR_BIT-1:0] cur_addr;
    logic [ADDR_BIT-1:0] last_addr;
    logic [ADDR_BIT:0]   issue_left;
    logic [ADDR_BIT:0]   out_left;
    logic [RD_LAT-1:0]   vld_sr;
    logic [DATA_BIT-1:0] fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic [CW-1:0]       fifo_cnt;
    logic [CW-1:0]       inflight_cnt;
    logic                push;
    logic                pop;

    always_comb begin
        inflight_cnt = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight_cnt = inflight_cnt + CW'(vld_sr[i]);
        end
    end

    assign req_ready = (state == IDLE);
    assign mem_ren   = (state == ISSUE) && ((inflight_cnt + fifo_cnt) < CW'(FIFO_DEPTH));
    // Memory sees the live address while reading, the last issued one otherwise.
    assign mem_addr  = mem_ren ? cur_addr : last_addr;
    assign mem_wen   = 1'b0;
    assign mem_wdata = '0;
    assign mem_bwe   = '0;

    assign push      = vld_sr[RD_LAT-1];
    assign out_valid = (fifo_cnt != '0);
    assign pop       = out_valid && out_ready;
    assign out_data  = out_valid ? fifo_mem[rd_ptr] : '0;
    assign out_last  = out_valid && (out_left == LEN_ONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cur_addr   <= '0;
            last_addr  <= '0;
            issue_left <= '0;
            out_left   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (pop) begin
                out_left <= out_left - LEN_ONE;
            end
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (req_len == '0) begin
                            done <= 1'b1;
                        end else begin
                            state      <= ISSUE;
                            busy       <= 1'b1;
                            cur_addr   <= req_addr;
                            issue_left <= req_len;
                            out_left   <= req_len;
                        end
                    end
                end
                ISSUE: begin
                    if (mem_ren) begin
                        last_addr  <= cur_addr;
                        cur_addr   <= (cur_addr == ADDR_BIT'(DEPTH - 1)) ? '0 : cur_addr + 1'b1;
                        issue_left <= issue_left - LEN_ONE;
                        if (issue_left == LEN_ONE) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && (out_left == LEN_ONE)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Clearing the tracker on reset is what discards words still in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_sr   <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            vld_sr[0] <= mem_ren;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_sr[i] <= vld_sr[i-1];
            end
            if (push) begin
                wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= mem_rdata;
        end
    end
endmodule

// File: tb/tb_mem_sp_burst_reader.sv
// Bench for mem_sp_burst_reader: random memory contents, directed and random bursts, reference queues.
module tb_mem_sp_burst_reader;
    localparam int DATA_BIT   = 32;
    localparam int DEPTH      = 128;
    localparam int ADDR_BIT   = 7;
    localparam int RD_LAT     = 2;
    localparam int FIFO_DEPTH = 4;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                req_valid;
    logic                req_ready;
    logic [ADDR_BIT-1:0] req_addr;
    logic [ADDR_BIT:0]   req_len;
    logic [ADDR_BIT-1:0] mem_addr;
    logic                mem_ren;
    logic                mem_wen;
    logic [DATA_BIT-1:0] mem_wdata;
    logic [DATA_BIT-1:0] mem_bwe;
    logic [DATA_BIT-1:0] mem_rdata;
    logic                out_valid;
    logic                out_ready;
    logic [DATA_BIT-1:0] out_data;
    logic                out_last;
    logic                busy;
    logic                done;

    mem_sp_burst_reader #(
        .DATA_BIT(DATA_BIT), .DEPTH(DEPTH), .ADDR_BIT(ADDR_BIT),
        .RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
        .mem_addr(mem_addr), .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
        .mem_bwe(mem_bwe), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Memory: contents fixed at start, read data valid RD_LAT cycles after the read cycle.
    logic [DATA_BIT-1:0] mem [DEPTH];
    logic [DATA_BIT-1:0] rd_pipe [RD_LAT];
    always @(posedge clk) begin
        rd_pipe[0] <= mem_ren ? mem[mem_addr] : $urandom;
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata = rd_pipe[RD_LAT-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [ADDR_BIT-1:0] obs_addr [$];
    int                  obs_rcyc [$];
    logic [DATA_BIT-1:0] obs_data [$];
    logic                obs_last [$];
    int                  done_cnt;
    int                  stab_err;
    int                  first_vld;
    logic                prev_stall = 1'b0;
    logic [DATA_BIT-1:0] prev_d;
    logic                prev_l;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (mem_ren) begin
                obs_addr.push_back(mem_addr);
                obs_rcyc.push_back(cyc);
            end
            if (out_valid && first_vld < 0) first_vld = cyc;
            if (out_valid && out_ready) begin
                obs_data.push_back(out_data);
                obs_last.push_back(out_last);
            end
            if (done) done_cnt++;
            if (prev_stall && (!out_valid || out_data !== prev_d || out_last !== prev_l)) stab_err++;
            prev_stall = out_valid && !out_ready;
            prev_d     = out_data;
            prev_l     = out_last;
        end
    end

    int passed = 0;
    int total  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, req_ready, 1);
        check({tag, "_mem_ren"}, mem_ren, 0);
        check({tag, "_mem_addr"}, mem_addr, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_last"}, out_last, 0);
        check({tag, "_out_data"}, out_data, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
    endtask

    // rmode: 0 = out_ready high, 1 = random out_ready, 2 = stalled 21 cycles then high.
    task automatic do_burst(input int addr, input int len, input int rmode);
        obs_addr.delete(); obs_rcyc.delete(); obs_data.delete(); obs_last.delete();
        done_cnt  = 0;
        stab_err  = 0;
        first_vld = -1;
        check("req_ready_idle", req_ready, 1);
        req_valid = 1'b1;
        req_addr  = addr[ADDR_BIT-1:0];
        req_len   = len[ADDR_BIT:0];
        out_ready = (rmode == 0);
        step;
        req_valid = 1'b0;
        if (len == 0) begin
            check("len0_done", done, 1);
            check("len0_busy", busy, 0);
            check("len0_ready", req_ready, 1);
        end else begin
            check("burst_busy", busy, 1);
            check("burst_not_ready", req_ready, 0);
        end
        for (int c = 0; c < 4000; c++) begin
            if (done_cnt > 0) break;
            out_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'($urandom_range(0, 1)) : (c > 20);
            step;
            if (rmode == 2 && c == 20) begin
                check("bp_reads", obs_addr.size(), FIFO_DEPTH);
                check("bp_ren_held_off", mem_ren, 0);
                check("bp_no_output", obs_data.size(), 0);
                check("bp_out_valid", out_valid, 1);
            end
        end
        check("done_seen", done_cnt > 0, 1);
        check("post_done_pulse_low", done, 0);
        check("post_done_busy", busy, 0);
        check("post_done_ready", req_ready, 1);
        out_ready = 1'b1;
        repeat (4) step;
        check("done_once", done_cnt, 1);
        check("read_count", obs_addr.size(), len);
        check("word_count", obs_data.size(), len);
        check("stall_stable", stab_err, 0);
        for (int i = 0; i < len && i < obs_addr.size(); i++)
            check("read_addr", obs_addr[i], (addr + i) % DEPTH);
        for (int i = 0; i < len && i < obs_data.size(); i++) begin
            check("out_data", obs_data[i], mem[(addr + i) % DEPTH]);
            check("out_last", obs_last[i], i == len - 1);
        end
        if (rmode == 0 && len > 0 && obs_rcyc.size() == len) begin
            check("reads_back_to_back", obs_rcyc[len-1] - obs_rcyc[0], len - 1);
            check("first_word_latency", first_vld - obs_rcyc[0], RD_LAT + 1);
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        req_len   = '0;
        out_ready = 1'b0;
        repeat (3) step;
        check_reset_outputs("reset");
        check("mem_wen", mem_wen, 0);
        check("mem_wdata", mem_wdata, 0);
        check("mem_bwe", mem_bwe, 0);
        rst_n = 1'b1;
        step;

        do_burst(5, 4, 0);
        do_burst(126, 4, 0);
        do_burst(0, 10, 2);
        do_burst(17, 0, 0);
        check("len0_no_reads", obs_addr.size(), 0);

        // Abort a len=8 burst three cycles in.
        done_cnt  = 0;
        req_valid = 1'b1;
        req_addr  = 7'd40;
        req_len   = 8'd8;
        out_ready = 1'b1;
        step;
        req_valid = 1'b0;
        repeat (3) step;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        repeat (2) step;
        check_reset_outputs("abort_hold");
        check("abort_no_done", done_cnt, 0);
        rst_n = 1'b1;
        step;
        do_burst(90, 2, 0);

        do_burst($urandom_range(0, DEPTH - 1), DEPTH, 1);
        for (int k = 0; k < 3; k++)
            do_burst($urandom_range(0, DEPTH - 1), $urandom_range(1, 20), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
